// File: rtl/split_slave.sv
// Split-capable memory slave: one-cycle writes, reads answered after SPLIT_LAT cycles and a re-grant.
// Optional macro SPLIT_TIMEOUT_EN adds a split_grant timeout that drops the read and pulses serr.
module split_slave #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int SPLIT_LAT = 4,
  parameter int GRANT_TO  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              svalid,
  input  logic              swrite,
  input  logic [ADDR_W-1:0] saddr,
  input  logic [DATA_W-1:0] swdata,
  input  logic              split_grant,
  output logic              sreadysp,
  output logic              ssplit,
  output logic [DATA_W-1:0] srdata,
  output logic              srvalid,
  output logic              serr
);

  typedef enum logic [1:0] {IDLE, SPLIT, WAIT_GRANT, RESP} state_t;

  if (SPLIT_LAT < 1 || SPLIT_LAT > 255 || GRANT_TO < 1 || GRANT_TO > 256) begin : g_param_check
    $error("split_slave: SPLIT_LAT must be 1..255 and GRANT_TO 1..256");
  end

  state_t            state, state_nxt;
  logic [7:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic rd_req, wr_req, lat_done, grant_hit;
  assign rd_req    = (state == IDLE) && svalid && !swrite;
  assign wr_req    = (state == IDLE) && svalid && swrite;
  assign lat_done  = (state == SPLIT) && (lat_cnt == 8'd0);
  assign grant_hit = (state == WAIT_GRANT) && split_grant;

`ifdef SPLIT_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       timeout;

  // Held at zero outside WAIT_GRANT, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     to_cnt <= 8'd0;
    else if (state != WAIT_GRANT)  to_cnt <= 8'd0;
    else                           to_cnt <= to_cnt + 8'd1;
  end

  assign timeout = (state == WAIT_GRANT) && (to_cnt == 8'(GRANT_TO - 1));
  assign serr    = timeout && !split_grant;
`else
  assign serr = 1'b0;
`endif

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:       if (svalid) state_nxt = swrite ? IDLE : SPLIT;
      SPLIT:      if (lat_cnt == 8'd0) state_nxt = WAIT_GRANT;
      WAIT_GRANT: begin
        if (split_grant) state_nxt = RESP;
`ifdef SPLIT_TIMEOUT_EN
        else if (timeout) state_nxt = IDLE;
`endif
      end
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      lat_cnt <= 8'd0;
      srdata  <= '0;
    end else begin
      state <= state_nxt;
      if (rd_req)
        lat_cnt <= 8'(SPLIT_LAT - 1);
      else if (state == SPLIT && lat_cnt != 8'd0)
        lat_cnt <= lat_cnt - 8'd1;
      if (grant_hit)
        srdata <= rdata_q;
    end
  end

  // NOTE: memory and its address/data staging are deliberately not reset; contents survive rstn.
  always_ff @(posedge clk) begin
    if (wr_req)   mem[saddr] <= swdata;
    if (rd_req)   addr_q     <= saddr;
    if (lat_done) rdata_q    <= mem[addr_q];
  end

  // Handshake outputs decode straight from the state register, so reset forces them at once.
  assign sreadysp = (state == IDLE);
  assign ssplit   = (state == SPLIT);
  assign srvalid  = (state == RESP);

endmodule

// File: tb/tb_split_slave.sv
// Directed bench for split_slave: a SPLIT_LAT=4 instance and a SPLIT_LAT=1 instance, scoreboard of read data.
// Timeout checks are compiled in when SPLIT_TIMEOUT_EN is defined.
module tb_split_slave;

  logic       clk = 1'b0;
  logic       rstn;
  always #5 clk = ~clk;

  logic       svalid, swrite, split_grant;
  logic [7:0] saddr, swdata;
  logic       sreadysp, ssplit, srvalid, serr;
  logic [7:0] srdata;

  logic       svalid_b, swrite_b, split_grant_b;
  logic [7:0] saddr_b, swdata_b;
  logic       sreadysp_b, ssplit_b, srvalid_b, serr_b;
  logic [7:0] srdata_b;

  split_slave #(.DATA_W(8), .ADDR_W(8), .SPLIT_LAT(4), .GRANT_TO(16)) u_dut (
    .clk(clk), .rstn(rstn), .svalid(svalid), .swrite(swrite), .saddr(saddr), .swdata(swdata),
    .split_grant(split_grant), .sreadysp(sreadysp), .ssplit(ssplit), .srdata(srdata),
    .srvalid(srvalid), .serr(serr)
  );

  split_slave #(.DATA_W(8), .ADDR_W(8), .SPLIT_LAT(1), .GRANT_TO(16)) u_lat1 (
    .clk(clk), .rstn(rstn), .svalid(svalid_b), .swrite(swrite_b), .saddr(saddr_b), .swdata(swdata_b),
    .split_grant(split_grant_b), .sreadysp(sreadysp_b), .ssplit(ssplit_b), .srdata(srdata_b),
    .srvalid(srvalid_b), .serr(serr_b)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] model_mem [256];
  logic [7:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pop_exp();
    logic [7:0] v;
    v = 8'hxx;
    if (exp_q.size() > 0) v = exp_q.pop_front();
    return v;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    svalid = 1'b1; swrite = 1'b1; saddr = a; swdata = d;
    model_mem[a] = d;
    step();
    svalid = 1'b0; swrite = 1'b0;
  endtask

  // Issues a read; optionally drives an illegal write to 0x30 during the first SPLIT cycle.
  task automatic issue_read(input logic [7:0] a, input bit inject, output int split_cyc);
    svalid = 1'b1; swrite = 1'b0; saddr = a;
    exp_q.push_back(model_mem[a]);
    step();
    svalid = inject; swrite = inject; saddr = 8'h30; swdata = 8'hFF;
    split_cyc = 0;
    while (ssplit === 1'b1 && split_cyc < 300) begin
      split_cyc++;
      step();
      svalid = 1'b0; swrite = 1'b0;
    end
    svalid = 1'b0; swrite = 1'b0;
  endtask

  // Waits gdly cycles in WAIT_GRANT, then grants and checks the response pulse.
  task automatic finish_read(input int gdly);
    logic [7:0] e;
    for (int i = 0; i < gdly; i++) begin
      check("wait_srvalid", srvalid, 1'b0);
      check("wait_sreadysp", sreadysp, 1'b0);
      check("wait_serr", serr, 1'b0);
      step();
    end
    split_grant = 1'b1;
    #1;
    check("grant_serr", serr, 1'b0);
    step();
    split_grant = 1'b0;
    e = pop_exp();
    check("resp_srvalid", srvalid, 1'b1);
    check("resp_srdata", srdata, e);
    step();
    check("post_srvalid", srvalid, 1'b0);
    check("post_sreadysp", sreadysp, 1'b1);
    check("post_srdata_hold", srdata, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    rstn = 1'b0;
    svalid = 0; swrite = 0; saddr = 0; swdata = 0; split_grant = 0;
    svalid_b = 0; swrite_b = 0; saddr_b = 0; swdata_b = 0; split_grant_b = 0;
    repeat (3) step();
    check("rst_sreadysp", sreadysp, 1'b1);
    check("rst_ssplit", ssplit, 1'b0);
    check("rst_srvalid", srvalid, 1'b0);
    check("rst_srdata", srdata, 8'h00);
    check("rst_serr", serr, 1'b0);
    check("rst_b_sreadysp", sreadysp_b, 1'b1);
    rstn = 1'b1;
    step();

    // Write then read with grant two cycles after ssplit falls.
    do_write(8'h30, 8'h00);
    do_write(8'h10, 8'hA5);
    check("write_sreadysp", sreadysp, 1'b1);
    issue_read(8'h10, 1'b0, sc);
    check("rd10_split_cycles", sc, 4);
    finish_read(2);

    // Back-to-back write then read of the same address.
    do_write(8'h20, 8'h3C);
    issue_read(8'h20, 1'b0, sc);
    check("rd20_split_cycles", sc, 4);
    finish_read(1);

    // Write attempted during SPLIT must be ignored.
    issue_read(8'h30, 1'b1, sc);
    check("rd30_inj_split_cycles", sc, 4);
    finish_read(3);
    issue_read(8'h30, 1'b0, sc);
    check("rd30_split_cycles", sc, 4);
    finish_read(1);

    // Spurious grant while idle.
    split_grant = 1'b1;
    step();
    split_grant = 1'b0;
    check("spur_srvalid", srvalid, 1'b0);
    check("spur_sreadysp", sreadysp, 1'b1);

    // Asynchronous reset in the middle of SPLIT discards the read.
    svalid = 1'b1; swrite = 1'b0; saddr = 8'h10;
    step();
    svalid = 1'b0;
    step();
    check("mid_ssplit", ssplit, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("arst_ssplit", ssplit, 1'b0);
    check("arst_sreadysp", sreadysp, 1'b1);
    check("arst_srvalid", srvalid, 1'b0);
    step();
    rstn = 1'b1;
    step();
    issue_read(8'h10, 1'b0, sc);
    check("rd10_after_rst_split_cycles", sc, 4);
    finish_read(2);

    // SPLIT_LAT = 1 instance.
    svalid_b = 1'b1; swrite_b = 1'b1; saddr_b = 8'h05; swdata_b = 8'h5A;
    step();
    svalid_b = 1'b1; swrite_b = 1'b0;
    exp_q.push_back(8'h5A);
    step();
    svalid_b = 1'b0;
    sc = 0;
    while (ssplit_b === 1'b1 && sc < 300) begin
      sc++;
      step();
    end
    check("lat1_split_cycles", sc, 1);
    check("lat1_wait_sreadysp", sreadysp_b, 1'b0);
    split_grant_b = 1'b1;
    step();
    split_grant_b = 1'b0;
    last_rd = pop_exp();
    check("lat1_srvalid", srvalid_b, 1'b1);
    check("lat1_srdata", srdata_b, last_rd);
    step();
    check("lat1_post_srvalid", srvalid_b, 1'b0);
    check("lat1_post_sreadysp", sreadysp_b, 1'b1);
    split_grant_b = 1'b1;
    step();
    split_grant_b = 1'b0;
    check("lat1_spur_srvalid", srvalid_b, 1'b0);
    step();
    check("lat1_spur_srvalid2", srvalid_b, 1'b0);
    check("lat1_serr", serr_b, 1'b0);

`ifdef SPLIT_TIMEOUT_EN
    // Grant never comes: serr on the 16th WAIT_GRANT cycle, read dropped.
    issue_read(8'h10, 1'b0, sc);
    void'(pop_exp());
    check("to_split_cycles", sc, 4);
    for (int i = 0; i < 15; i++) begin
      check("to_wait_serr", serr, 1'b0);
      check("to_wait_srvalid", srvalid, 1'b0);
      step();
    end
    check("to_serr", serr, 1'b1);
    check("to_srvalid", srvalid, 1'b0);
    step();
    check("to_post_serr", serr, 1'b0);
    check("to_post_srvalid", srvalid, 1'b0);
    check("to_post_sreadysp", sreadysp, 1'b1);

    // Grant on the expiry cycle wins.
    issue_read(8'h10, 1'b0, sc);
    check("to_grant_split_cycles", sc, 4);
    finish_read(15);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
